// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU operations and memory-mapped I/O addresses.
package riscv_mc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] IO_GPIO_OUT = 32'h1000_0000;
  localparam logic [31:0] IO_GPIO_IN  = 32'h1000_0004;
  localparam logic [31:0] IO_DEV_OUT  = 32'h1000_0008;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_JAL,
    S_JALR,
    S_BRANCH,
    S_UPPER,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_t;

  // funct7[5] only selects sub for register-register ops; addi ignores it.
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3,
                                            input logic       funct7_b5,
                                            input logic       is_reg);
    alu_op_t op;
    case (funct3)
      3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_mc_alu.sv
// Combinational ALU shared by every state of the multi-cycle core.
module riscv_mc_alu
  import riscv_mc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = 32'b0;
    case (alu_op_t'(op))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      default: y = a + b;
    endcase
  end

  assign zero = (y == 32'b0);

endmodule

// File: rtl/riscv_multi_cycle_core.sv
// Multi-cycle RV32I-subset core with unified memory and 8-bit memory-mapped ports.
// Optional ILLEGAL_TRAP_EN: unknown opcodes halt the core and set Device_Out to 8'hFF.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | IR <= mem[PC], OldPC <= PC, PC <= PC+4
// DECODE   | latch rs1/rs2, precompute branch target, dispatch on opcode
// MEMADR   | effective address for lw/sw
// MEMREAD  | bus read into Data
// MEMWB    | rd <= Data
// MEMWRITE | bus write of rs2 (memory or output port)
// EXEC_R   | ALUOut <= rs1 op rs2
// EXEC_I   | ALUOut <= rs1 op immI
// ALUWB    | rd <= ALUOut
// JAL      | rd <= PC, PC <= OldPC+immJ
// JALR     | rd <= PC, PC <= (rs1+immI) & ~1
// BRANCH   | PC <= target when beq/bne condition holds
// UPPER    | rd <= lui ? immU : OldPC+immU
// HALT     | trapped on illegal opcode, waits for reset
module riscv_multi_cycle_core
  import riscv_mc_pkg::*;
#(
  parameter int    MEM_DEPTH = 256,
  parameter string MEM_FILE  = "prog.hex"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] GPIO_In,
  output logic [7:0] GPIO_Out,
  output logic [7:0] Device_Out
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] rf  [32];

  state_t      state, state_next;
  logic [31:0] pc, old_pc, ir, a_reg, b_reg, alu_out, data_reg;
  logic [7:0]  gpio_out_q, dev_out_q;

  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;
  logic        alu_zero;

  logic        pc_we, rf_we, alu_out_we, bus_we, mem_we, trap_set;
  logic [31:0] pc_next, rf_wdata, bus_rdata, bus_addr;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  riscv_mc_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Byte offset within the word is ignored for both decode and memory index.
  assign bus_addr = {alu_out[31:2], 2'b00};

  always_comb begin
    case (bus_addr)
      IO_GPIO_OUT: bus_rdata = {24'b0, gpio_out_q};
      IO_GPIO_IN:  bus_rdata = {24'b0, GPIO_In};
      IO_DEV_OUT:  bus_rdata = {24'b0, dev_out_q};
      default:     bus_rdata = mem[alu_out[AW+1:2]];
    endcase
  end

  assign mem_we = bus_we && (bus_addr != IO_GPIO_OUT) && (bus_addr != IO_GPIO_IN)
                  && (bus_addr != IO_DEV_OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_a      = 32'b0;
    alu_b      = 32'b0;
    alu_op     = ALU_ADD;
    alu_out_we = 1'b0;
    pc_we      = 1'b0;
    pc_next    = alu_y;
    rf_we      = 1'b0;
    rf_wdata   = alu_y;
    bus_we     = 1'b0;
    trap_set   = 1'b0;
    case (state)
      S_FETCH: begin
        alu_a      = pc;
        alu_b      = 32'd4;
        pc_we      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_a      = old_pc;
        alu_b      = imm_b;
        alu_out_we = 1'b1;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_REG:            state_next = S_EXEC_R;
          OP_IMM:            state_next = S_EXEC_I;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_LUI, OP_AUIPC:  state_next = S_UPPER;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = S_HALT;
            trap_set   = 1'b1;
`else
            state_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_a      = a_reg;
        alu_b      = (opcode == OP_STORE) ? imm_s : imm_i;
        alu_out_we = 1'b1;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_wdata   = data_reg;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        bus_we     = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_a      = a_reg;
        alu_b      = b_reg;
        alu_op     = alu_op_decode(funct3, ir[30], 1'b1);
        alu_out_we = 1'b1;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_a      = a_reg;
        alu_b      = imm_i;
        alu_op     = alu_op_decode(funct3, ir[30], 1'b0);
        alu_out_we = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        rf_wdata   = alu_out;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_a      = old_pc;
        alu_b      = imm_j;
        pc_we      = 1'b1;
        rf_we      = 1'b1;
        rf_wdata   = pc;
        state_next = S_FETCH;
      end
      S_JALR: begin
        alu_a      = a_reg;
        alu_b      = imm_i;
        pc_we      = 1'b1;
        pc_next    = alu_y & ~32'd1;
        rf_we      = 1'b1;
        rf_wdata   = pc;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        // Compare via subtract; target was computed during DECODE.
        alu_a      = a_reg;
        alu_b      = b_reg;
        alu_op     = ALU_SUB;
        pc_next    = alu_out;
        pc_we      = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);
        state_next = S_FETCH;
      end
      S_UPPER: begin
        alu_a      = (opcode == OP_LUI) ? 32'b0 : old_pc;
        alu_b      = imm_u;
        rf_we      = 1'b1;
        rf_wdata   = alu_y;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= 32'b0;
      old_pc     <= 32'b0;
      ir         <= 32'b0;
      a_reg      <= 32'b0;
      b_reg      <= 32'b0;
      alu_out    <= 32'b0;
      data_reg   <= 32'b0;
      gpio_out_q <= 8'b0;
      dev_out_q  <= 8'b0;
    end else begin
      if (state == S_FETCH) begin
        ir     <= mem[pc[AW+1:2]];
        old_pc <= pc;
      end
      if (pc_we) pc <= pc_next;
      if (state == S_DECODE) begin
        a_reg <= (rs1 == 5'd0) ? 32'b0 : rf[rs1];
        b_reg <= (rs2 == 5'd0) ? 32'b0 : rf[rs2];
      end
      if (alu_out_we) alu_out <= alu_y;
      if (state == S_MEMREAD) data_reg <= bus_rdata;
      if (bus_we && (bus_addr == IO_GPIO_OUT)) gpio_out_q <= b_reg[7:0];
      if (bus_we && (bus_addr == IO_DEV_OUT))  dev_out_q  <= b_reg[7:0];
      if (trap_set) dev_out_q <= 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'b0;
    end else if (rf_we && (rd != 5'd0)) begin
      rf[rd] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[alu_out[AW+1:2]] <= b_reg;
  end

  assign GPIO_Out   = gpio_out_q;
  assign Device_Out = dev_out_q;

endmodule

// File: tb/tb_riscv_multi_cycle_core.sv
// Self-checking bench for riscv_multi_cycle_core: directed programs plus random
// straight-line programs checked against an instruction-level reference model.
module tb_riscv_multi_cycle_core;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [31:0] A_GOUT = 32'h1000_0000, A_GIN = 32'h1000_0004, A_DOUT = 32'h1000_0008;
  localparam logic [31:0] JAL_SELF = 32'h0000_006F;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out, device_out;

  always #5 clk = ~clk;

  riscv_multi_cycle_core #(.MEM_DEPTH(256), .MEM_FILE("")) dut (
    .clk        (clk),
    .reset      (reset),
    .GPIO_In    (gpio_in),
    .GPIO_Out   (gpio_out),
    .Device_Out (device_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog [$];
  logic [31:0] m_mem  [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [7:0]  m_gout, m_dout;
  logic        m_halt;

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic sub,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return sub ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return a >> b[4:0];
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (w == A_GOUT) return {24'b0, m_gout};
    if (w == A_GIN)  return {24'b0, gpio_in};
    if (w == A_DOUT) return {24'b0, m_dout};
    return m_mem[addr[9:2]];
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    if (w == A_GOUT)      m_gout = data[7:0];
    else if (w == A_DOUT) m_dout = data[7:0];
    else if (w != A_GIN)  m_mem[addr[9:2]] = data;
  endtask

  task automatic ref_wr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) m_regs[rd] = v;
  endtask

  // One architectural instruction; cyc returns its cycle cost.
  task automatic ref_step(output int cyc);
    logic [31:0] ins, ii, si, bi, ui, ji, a, b, nxt;
    ins = m_mem[m_pc[9:2]];
    ii  = {{20{ins[31]}}, ins[31:20]};
    si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ui  = {ins[31:12], 12'b0};
    ji  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    nxt = m_pc + 4;
    case (ins[6:0])
      OP_LUI:   begin ref_wr(ins[11:7], ui);        cyc = 3; end
      OP_AUIPC: begin ref_wr(ins[11:7], m_pc + ui); cyc = 3; end
      OP_JAL:   begin ref_wr(ins[11:7], m_pc + 4); nxt = m_pc + ji; cyc = 3; end
      OP_JALR:  begin nxt = (a + ii) & ~32'd1; ref_wr(ins[11:7], m_pc + 4); cyc = 3; end
      OP_BR: begin
        if ((ins[14:12] == 3'd0 && a == b) || (ins[14:12] == 3'd1 && a != b)) nxt = m_pc + bi;
        cyc = 3;
      end
      OP_LOAD:  begin ref_wr(ins[11:7], ref_load(a + ii)); cyc = 5; end
      OP_STORE: begin ref_store(a + si, b); cyc = 4; end
      OP_IMM:   begin ref_wr(ins[11:7], ref_alu(ins[14:12], 1'b0, a, ii)); cyc = 4; end
      OP_REG:   begin ref_wr(ins[11:7], ref_alu(ins[14:12], ins[30], a, b)); cyc = 4; end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        m_halt = 1'b1;
        m_dout = 8'hFF;
`endif
        cyc = 2;
      end
    endcase
    m_pc = nxt;
  endtask

  // Runs the model until it reaches a self-loop or halts; returns total cycles.
  task automatic ref_run(output int cycles);
    int c;
    bit done;
    cycles = 0;
    done = 0;
    for (int n = 0; n < 500; n++) begin
      if (m_halt || m_mem[m_pc[9:2]] == JAL_SELF) begin
        done = 1;
        break;
      end
      ref_step(c);
      cycles += c;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL model_bound: got %0d instructions without reaching end, required < 500", 500);
    end
  endtask

  task automatic load_and_reset();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = JAL_SELF;
    for (int i = 128; i < 144; i++) m_mem[i] = $urandom();
    foreach (prog[i]) m_mem[i] = prog[i];
    for (int i = 0; i < 256; i++) dut.mem[i] = m_mem[i];
    for (int i = 0; i < 32; i++) m_regs[i] = 32'b0;
    m_pc = 32'b0; m_gout = 8'h00; m_dout = 8'h00; m_halt = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    prog = {};
    prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'h05A));
    prog.push_back(enc_s(12'd0, 5'd1, 5'd5));
    prog.push_back(enc_s(12'd8, 5'd1, 5'd5));
    load_and_reset();
    tick(20);
    reset = 1'b0;
    tick(3);
    n_cmp++; if (gpio_out !== 8'h00) begin n_bad++; $display("FAIL reset_gpio_out: got %h required 00", gpio_out); end
    n_cmp++; if (device_out !== 8'h00) begin n_bad++; $display("FAIL reset_device_out: got %h required 00", device_out); end
    n_cmp++; if (dut.pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h required 0", dut.pc); end
    n_cmp++; if (dut.rf[1] !== 32'h0) begin n_bad++; $display("FAIL reset_x1: got %h required 0", dut.rf[1]); end
    n_cmp++; if (dut.ir !== 32'h0) begin n_bad++; $display("FAIL reset_ir: got %h required 0", dut.ir); end
    reset = 1'b1;
    tick(1);
    n_cmp++; if (dut.ir !== prog[0]) begin n_bad++; $display("FAIL first_fetch_ir: got %h required %h", dut.ir, prog[0]); end
    n_cmp++; if (dut.pc !== 32'h4) begin n_bad++; $display("FAIL first_fetch_pc: got %h required 4", dut.pc); end
  endtask

  task automatic test_gpio_load_store();
    int cyc;
    prog = {};
    prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
    prog.push_back(enc_i(OP_LOAD, 5'd1, 3'd2, 5'd5, 12'd4));
    prog.push_back(enc_s(12'd0, 5'd1, 5'd5));
    gpio_in = 8'h12;
    load_and_reset();
    ref_run(cyc);
    tick(11);
    n_cmp++; if (gpio_out !== 8'h00) begin n_bad++; $display("FAIL gpio_before_memwrite: got %h required 00", gpio_out); end
    tick(1);
    n_cmp++; if (gpio_out !== 8'h12) begin n_bad++; $display("FAIL gpio_lw_sw: got %h required 12", gpio_out); end
    n_cmp++; if (dut.rf[1] !== 32'h12) begin n_bad++; $display("FAIL lw_zero_ext: got %h required 00000012", dut.rf[1]); end
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL model_cycles_lw_sw: got %0d required 12", cyc); end
  endtask

  task automatic test_alu_to_device();
    prog = {};
    prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'd5));
    prog.push_back(enc_i(OP_IMM, 5'd2, 3'd0, 5'd0, 12'd7));
    prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    prog.push_back(enc_s(12'd8, 5'd3, 5'd5));
    prog.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
    prog.push_back(enc_s(12'd8, 5'd4, 5'd5));
    load_and_reset();
    tick(19);
    n_cmp++; if (device_out !== 8'h0C) begin n_bad++; $display("FAIL add_to_device: got %h required 0C", device_out); end
    tick(8);
    n_cmp++; if (device_out !== 8'hFE) begin n_bad++; $display("FAIL sub_to_device: got %h required FE", device_out); end
  endtask

  task automatic test_branch_loop();
    int cyc;
    prog = {};
    prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
    prog.push_back(enc_i(OP_IMM, 5'd2, 3'd0, 5'd0, 12'd3));
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd1, 12'd1));
    prog.push_back(enc_b(13'h1FFC, 5'd2, 5'd1, 3'd1));
    prog.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'd0));
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'd99));
    prog.push_back(enc_b(13'd8, 5'd2, 5'd0, 3'd0));
    prog.push_back(enc_s(12'd0, 5'd1, 5'd5));
    load_and_reset();
    ref_run(cyc);
    tick(cyc);
    n_cmp++; if (gpio_out !== 8'h03) begin n_bad++; $display("FAIL branch_loop_gpio: got %h required 03", gpio_out); end
    n_cmp++; if (dut.rf[1] !== 32'd3) begin n_bad++; $display("FAIL beq_taken_skip: got %h required 3", dut.rf[1]); end
    n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL branch_end_pc: got %h required %h", dut.pc, m_pc); end
  endtask

  task automatic test_x0_and_jal();
    prog = {};
    prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'h055));
    prog.push_back(enc_s(12'd0, 5'd1, 5'd5));
    prog.push_back(enc_i(OP_IMM, 5'd0, 3'd0, 5'd0, 12'd9));
    prog.push_back(enc_s(12'd0, 5'd0, 5'd5));
    prog.push_back(enc_j(5'd1, 21'd8));
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'h077));
    prog.push_back(enc_s(12'd8, 5'd1, 5'd5));
    load_and_reset();
    tick(11);
    n_cmp++; if (gpio_out !== 8'h55) begin n_bad++; $display("FAIL gpio_pre_x0: got %h required 55", gpio_out); end
    tick(15);
    n_cmp++; if (gpio_out !== 8'h00) begin n_bad++; $display("FAIL x0_write_discard: got %h required 00", gpio_out); end
    n_cmp++; if (device_out !== 8'h18) begin n_bad++; $display("FAIL jal_link: got %h required 18", device_out); end
    n_cmp++; if (dut.rf[1] !== 32'd24) begin n_bad++; $display("FAIL jal_skip: got %h required 24", dut.rf[1]); end
  endtask

  task automatic test_reset_mid_write();
    prog = {};
    prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'h0A5));
    prog.push_back(enc_s(12'd0, 5'd1, 5'd5));
    load_and_reset();
    tick(10);
    reset = 1'b0;
    tick(3);
    n_cmp++; if (gpio_out !== 8'h00) begin n_bad++; $display("FAIL abort_memwrite: got %h required 00", gpio_out); end
    n_cmp++; if (dut.pc !== 32'h0) begin n_bad++; $display("FAIL abort_pc: got %h required 0", dut.pc); end
    reset = 1'b1;
    tick(11);
    n_cmp++; if (gpio_out !== 8'hA5) begin n_bad++; $display("FAIL rerun_after_abort: got %h required A5", gpio_out); end
  endtask

  task automatic test_illegal_opcode();
    int cyc;
    prog = {};
    prog.push_back(enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'h03C));
    prog.push_back(32'h0000_0000);
    prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
    prog.push_back(enc_s(12'd0, 5'd1, 5'd5));
    load_and_reset();
    ref_run(cyc);
    tick(13);
`ifdef ILLEGAL_TRAP_EN
    n_cmp++; if (device_out !== 8'hFF) begin n_bad++; $display("FAIL trap_device: got %h required FF", device_out); end
    n_cmp++; if (gpio_out !== 8'h00) begin n_bad++; $display("FAIL trap_halts: got %h required 00", gpio_out); end
`else
    n_cmp++; if (gpio_out !== 8'h3C) begin n_bad++; $display("FAIL illegal_nop: got %h required 3C", gpio_out); end
    n_cmp++; if (device_out !== 8'h00) begin n_bad++; $display("FAIL illegal_nop_dev: got %h required 00", device_out); end
`endif
    n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL illegal_pc: got %h required %h", dut.pc, m_pc); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 4));
    rs1 = 5'($urandom_range(0, 4));
    rs2 = 5'($urandom_range(0, 4));
    case ($urandom_range(0, 5))
      0: begin
        case ($urandom_range(0, 6))
          0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd4; 3: f3 = 3'd6;
          4: f3 = 3'd7; 5: f3 = 3'd1; default: f3 = 3'd5;
        endcase
        imm = (f3 == 3'd1 || f3 == 3'd5) ? {7'b0, 5'($urandom_range(0, 31))} : 12'($urandom());
        return enc_i(OP_IMM, rd, f3, rs1, imm);
      end
      1: begin
        case ($urandom_range(0, 6))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
          4: f3 = 3'd5; 5: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        return enc_r((f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      end
      2: return enc_u($urandom_range(0, 1) ? OP_LUI : OP_AUIPC, rd, 20'($urandom()));
      3: begin
        if ($urandom_range(0, 1) == 1) return enc_s({6'b0, 4'($urandom_range(0, 15)), 2'b00}, rs2, 5'd6);
        return enc_s(12'($urandom_range(0, 2) * 4), rs2, 5'd5);
      end
      4: begin
        if ($urandom_range(0, 1) == 1)
          return enc_i(OP_LOAD, rd, 3'd2, 5'd6, {6'b0, 4'($urandom_range(0, 15)), 2'b00});
        return enc_i(OP_LOAD, rd, 3'd2, 5'd5, 12'($urandom_range(0, 2) * 4));
      end
      default: return enc_b(13'd8, rs2, rs1, $urandom_range(0, 1) ? 3'd1 : 3'd0);
    endcase
  endfunction

  task automatic test_random();
    int cyc;
    for (int it = 0; it < 25; it++) begin
      prog = {};
      prog.push_back(enc_u(OP_LUI, 5'd5, 20'h10000));
      prog.push_back(enc_i(OP_IMM, 5'd6, 3'd0, 5'd0, 12'h200));
      for (int k = 0; k < 14; k++) prog.push_back(rand_instr());
      gpio_in = 8'($urandom());
      load_and_reset();
      ref_run(cyc);
      tick(cyc);
      for (int r = 1; r <= 4; r++) begin
        n_cmp++;
        if (dut.rf[r] !== m_regs[r]) begin
          n_bad++;
          $display("FAIL rand_reg it=%0d x%0d: got %h required %h", it, r, dut.rf[r], m_regs[r]);
        end
      end
      n_cmp++; if (gpio_out !== m_gout) begin n_bad++; $display("FAIL rand_gpio it=%0d: got %h required %h", it, gpio_out, m_gout); end
      n_cmp++; if (device_out !== m_dout) begin n_bad++; $display("FAIL rand_dev it=%0d: got %h required %h", it, device_out, m_dout); end
      n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL rand_pc it=%0d: got %h required %h", it, dut.pc, m_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_gpio_load_store();
    test_alu_to_device();
    test_branch_loop();
    test_x0_and_jal();
    test_reset_mid_write();
    test_illegal_opcode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
